// File: rtl/serial_pkg.sv
// Shared definitions for the serial bit transmitter slice: FSM state type,
// default frame width and the bit-counter width helper.
package serial_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Counter must hold FRAME_LEN-1 down to 0; sized to also fit FRAME_LEN.
  function automatic int cnt_width(input int frame_len);
    return $clog2(frame_len + 1);
  endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// Loadable shift register feeding the serial transmitter. Exposes the bit
// that will sit at the output end after the next shift, so the top can
// register sout one cycle ahead without a second copy of the word.
module serial_shift_reg
  import serial_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             next_bit
);

  logic [WIDTH-1:0] data_p0;

  // Word storage: load wins over shift; vacated positions fill with zero.
  always_ff @(posedge clk) begin
    if (load) begin
      data_p0 <= din;
    end else if (shift) begin
      if (MSB_FIRST != 0) begin
        data_p0 <= {data_p0[WIDTH-2:0], 1'b0};
      end else begin
        data_p0 <= {1'b0, data_p0[WIDTH-1:1]};
      end
    end
  end

  assign next_bit = (MSB_FIRST != 0) ? data_p0[WIDTH-2] : data_p0[1];

endmodule

// File: rtl/serial_bit_tx.sv
// Parallel-in, serial-out bit transmitter. Accepts a WIDTH-bit word over a
// valid/ready handshake and emits it one bit per clock with a per-bit valid
// and a frame-start marker. Back-to-back frames run without gaps.
// Optional: define SERIAL_BIT_TX_PARITY_EN to append an even-parity bit
// after the data bits of every frame.
module serial_bit_tx
  import serial_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             busy
);

`ifdef SERIAL_BIT_TX_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CNT_W = cnt_width(FRAME_LEN);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rdy_en_q;
  logic             last_bit;
  logic             accept;
  logic             shift_en;
  logic             first_bit;
  logic             shift_nxt;
  logic             nxt_bit;

  // din_ready is the only combinational output. rdy_en_q keeps it low in
  // reset and for the release cycle so a producer never sees a ready that
  // the first post-reset edge could not honour.
  assign last_bit  = (state_q == SHIFT) && (cnt_q == '0);
  assign din_ready = rdy_en_q && ((state_q == IDLE) || last_bit);
  assign accept    = din_valid && din_ready;
  assign shift_en  = (state_q == SHIFT) && !last_bit;
  assign first_bit = (MSB_FIRST != 0) ? din[WIDTH-1] : din[0];

  serial_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk      (clk),
    .load     (accept),
    .shift    (shift_en),
    .din      (din),
    .next_bit (shift_nxt)
  );

`ifdef SERIAL_BIT_TX_PARITY_EN
  logic parity_p0;

  // Even parity of the accepted word, held until the trailing parity bit.
  always_ff @(posedge clk) begin
    if (accept) begin
      parity_p0 <= ^din;
    end
  end

  // Counter value 1 means the last data bit is on sout; parity goes next.
  assign nxt_bit = (cnt_q == CNT_W'(1)) ? parity_p0 : shift_nxt;
`else
  assign nxt_bit = shift_nxt;
`endif

  // Control FSM, bit counter and registered serial outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rdy_en_q    <= 1'b0;
      sout        <= 1'b0;
      sout_valid  <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      if (accept) begin
        state_q     <= SHIFT;
        cnt_q       <= CNT_W'(FRAME_LEN - 1);
        sout        <= first_bit;
        sout_valid  <= 1'b1;
        frame_start <= 1'b1;
        busy        <= 1'b1;
      end else if (shift_en) begin
        cnt_q       <= cnt_q - CNT_W'(1);
        sout        <= nxt_bit;
        frame_start <= 1'b0;
      end else begin
        state_q     <= IDLE;
        sout        <= 1'b0;
        sout_valid  <= 1'b0;
        frame_start <= 1'b0;
        busy        <= 1'b0;
      end
    end
  end

endmodule

// File: doc/serial_bit_tx.md
Name: serial_bit_tx

Overview:
- Parallel-in, serial-out transmitter that produces the one-bit-per-clock D stream our D flip-flop capture path samples.
- Accepts a WIDTH-bit word over a valid/ready handshake, shifts it out one bit per clk with a per-bit valid and a frame-start marker.
- Sits between a word-level producer and any single-bit sampling stage.
- Supports gapless back-to-back frames.

Parameters:
- WIDTH, 8, data bits per frame; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- din  input  WIDTH  parallel word; sampled only on an accept.
- din_valid  input  1  producer has a word on din.
- din_ready  output  1  block can accept a word this cycle.
- sout  output  1  serial data bit (the D stream).
- sout_valid  output  1  sout carries a frame bit this cycle.
- frame_start  output  1  high with the first bit of each frame.
- busy  output  1  a frame is in progress.

Behaviour:
- Reset is asynchronous assert, synchronous release. While reset=0 all outputs are 0 and the state is IDLE: sout=0, sout_valid=0, frame_start=0, busy=0, din_ready=0.
- din_ready is held 0 during reset. It rises on the first clk edge after reset deasserts.
- Accept occurs when din_valid and din_ready are both high at a rising edge. The word is latched into the shift register and the bit counter loads FRAME_LEN-1.
- FRAME_LEN = WIDTH, or WIDTH+1 when the parity option is enabled. The counter width is $clog2(FRAME_LEN+1).
- FSM states:
  - IDLE: din_ready=1, sout_valid=0. Goes to SHIFT on accept.
  - SHIFT: sout_valid=1, busy=1. Shifts one bit per edge and decrements the counter.
- Latency: the first bit appears on sout in the cycle after the accept edge. frame_start=1 for that cycle only.
- Bit order:
  - MSB_FIRST=1: sout = shift[WIDTH-1], and the register shifts left.
  - MSB_FIRST=0: sout = shift[0], and the register shifts right.
- Last-bit cycle (counter==0 in SHIFT): din_ready=1.
  - If an accept occurs, the next frame's first bit follows with no gap. State stays SHIFT and frame_start pulses again.
  - If no accept occurs, go to IDLE and sout_valid drops next cycle.
- In SHIFT with counter>0, din_ready=0. din_valid is ignored and din may change freely.
- sout=0 whenever sout_valid=0.
- din_valid is not required to stay asserted. The producer may withdraw it while din_ready=0 with no effect.
- Reset asserted mid-frame aborts the frame immediately (asynchronously). No residual bits are emitted after release.
- All outputs are registered except din_ready, which is decoded from state and counter.

Optional Feature:
- Macro: SERIAL_BIT_TX_PARITY_EN.
- Defined: after the WIDTH data bits, one extra bit carrying even parity (XOR of all din bits) is sent with sout_valid=1. FRAME_LEN = WIDTH+1, and the last-bit/din_ready rules apply to the parity bit.
- Undefined: no parity logic or storage. FRAME_LEN = WIDTH.

Decomposition:
- Shared package serial_pkg holds:
  - state typedef (IDLE, SHIFT);
  - DEFAULT_WIDTH constant;
  - helper function for counter width.
- One natural sub-module, serial_shift_reg: a loadable shift register with direction parameter, load and shift enables. The FSM, counter and handshake stay in the top.

Test Plan:
1. Reset: hold reset=0 for 3 cycles with din_valid=1 -> all outputs 0, no accept. After release, din_ready=1 on the next edge.
2. Single frame, WIDTH=8, MSB_FIRST=1, din=8'hA5 -> sout = 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting the cycle after accept. frame_start only on the first; then sout_valid=0 and busy=0.
3. MSB_FIRST=0, din=8'h01 -> sout = 1,0,0,0,0,0,0,0. din changed to 8'hFF mid-frame does not corrupt the output.
4. Back-to-back: din_valid held 1 with 8'hF0 then 8'h0F -> 16 contiguous valid bits 1111000000001111. frame_start high at bit 0 and bit 8; din_ready high only on bits 7 and 15 (and in IDLE).
5. Reset mid-frame: assert reset=0 after bit 3 of 8'hFF -> sout and sout_valid go to 0 immediately. After release, a new din=8'h81 transmits cleanly.
6. With SERIAL_BIT_TX_PARITY_EN, din=8'h07 -> 8 data bits, then a 9th bit = 1 (odd count of ones gives parity 1). din_ready rises on the 9th bit.
